// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared CPU definitions used by fetch, decode and memory
//               blocks: memory geometry, reset PC, halt opcode, opcode field
//               position and fetch FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    localparam int unsigned DEF_MEM_DEPTH   = 100;
    localparam logic [31:0] DEF_RESET_PC    = 32'd0;
    localparam logic [5:0]  DEF_HALT_OPCODE = 6'b111111;

    // Opcode field location inside a 32-bit instruction word
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    // Fetch FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // True when the instruction carries the given opcode in its opcode field
    function automatic logic is_opcode(input logic [31:0] instr, input logic [5:0] opcode);
        return instr[OPCODE_MSB:OPCODE_LSB] == opcode;
    endfunction

endpackage : instruction_fetch_unit_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_fetch_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_counter
// Description : Program counter register with load, increment and wrap at
//               the end of instruction memory. Load wins over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_counter #(
    parameter int unsigned MEM_DEPTH = 100,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        incr,
    output logic [31:0] pc
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 1);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: redirect load, else sequential step wrapping past the last word
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (incr) begin
            pc_d = (pc_q == LAST_ADDR) ? 32'd0 : pc_q + 32'd1;
        end
    end

    // PC register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule : fetch_pc_counter
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetches one instruction per cycle from a combinational
//               instruction memory into a valid/ready output register.
//               Supports redirects, halts on a halt opcode and faults on
//               out-of-range redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [5:0]  HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    logic [1:0]  state_q,     state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q,    out_pc_d;
    logic        fault_q,     fault_d;

    logic        pc_load;
    logic        pc_incr;
    logic [31:0] pc;

    fetch_pc_counter #(
        .MEM_DEPTH (MEM_DEPTH),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pc_load),
        .load_value (redirect_pc),
        .incr       (pc_incr),
        .pc         (pc)
    );

    // FSM next state, output register capture and PC control
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        fault_d     = fault_q;
        pc_load     = 1'b0;
        pc_incr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    // Redirect flushes the output even if it is being accepted
                    out_valid_d = 1'b0;
                    if (redirect_pc >= DEPTH_W) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_instr;
                    out_pc_d    = pc;
                    if (is_opcode(imem_instr, HALT_OPCODE)) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_incr = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                // Drain the last delivered instruction, then stay quiet
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_addr = pc;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = (state_q == ST_HALT);
    assign fault     = fault_q;

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit with
//               a behavioural 100-word instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:99];

    instruction_fetch_unit #(
        .MEM_DEPTH   (100),
        .RESET_PC    (32'd0),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range addresses read zero
    always_comb begin
        imem_instr = 32'd0;
        if (imem_addr < 32'd100) imem_instr = mem[imem_addr[6:0]];
    end

    // Reference contents: opcode 000001 with a per-address payload
    function automatic logic [31:0] word_at(input int a);
        if (a == 0) return 32'h80210010;
        return 32'h04000000 + 32'(a) * 32'h111;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc_exp, input logic [31:0] ins_exp);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"},    out_pc,         pc_exp);
        chk({tag, "_instr"}, out_instr,      ins_exp);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"},  32'(out_valid), 32'd0);
        chk({tag, "_pc"},     out_pc,         32'd0);
        chk({tag, "_instr"},  out_instr,      32'd0);
        chk({tag, "_halted"}, 32'(halted),    32'd0);
        chk({tag, "_fault"},  32'(fault),     32'd0);
        chk({tag, "_addr"},   imem_addr,      32'd0);
    endtask

    initial begin
        for (int i = 0; i < 100; i++) mem[i] = word_at(i);
        rst_n          = 1'b0;
        start          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        @(negedge clk);
        tick();
        chk_cleared("reset");

        // IDLE holds and ignores redirect
        rst_n          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd30;
        tick();
        redirect_valid = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_addr", imem_addr, 32'd0);

        // Start: first capture one cycle after entering FETCH
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_novalid", 32'(out_valid), 32'd0);
        tick();
        chk_out("seq0", 32'd0, 32'h80210010);
        tick();
        chk_out("seq1", 32'd1, word_at(1));
        tick();
        chk_out("seq2", 32'd2, word_at(2));
        chk("seq2_addr", imem_addr, 32'd3);

        // Backpressure holds everything for three cycles
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("stall", 32'd2, word_at(2));
            chk("stall_addr", imem_addr, 32'd3);
        end
        out_ready = 1'b1;
        tick();
        chk_out("resume3", 32'd3, word_at(3));
        tick();
        tick();
        chk_out("seq5", 32'd5, word_at(5));

        // Redirect flushes, then target appears
        redirect_valid = 1'b1;
        redirect_pc    = 32'd40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flush", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'd40);
        tick();
        chk_out("redir40", 32'd40, word_at(40));
        chk("redir40_addr", imem_addr, 32'd41);

        // Wrap at end of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'd99;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_flush", 32'(out_valid), 32'd0);
        tick();
        chk_out("wrap99", 32'd99, word_at(99));
        tick();
        chk_out("wrap0", 32'd0, 32'h80210010);

        // Halt opcode at address 7
        mem[7] = 32'hFC000000;
        for (int k = 1; k < 7; k++) tick();
        chk_out("pre_halt6", 32'd6, word_at(6));
        chk("pre_halt_halted", 32'(halted), 32'd0);
        tick();
        chk_out("halt7", 32'd7, 32'hFC000000);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_addr", imem_addr, 32'd7);

        // Pending output held, redirect ignored in HALT
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd20;
        tick();
        redirect_valid = 1'b0;
        chk_out("halt_hold", 32'd7, 32'hFC000000);
        chk("halt_ign_addr", imem_addr, 32'd7);
        out_ready = 1'b1;
        tick();
        chk("halt_drain", 32'(out_valid), 32'd0);
        chk("halt_drain_pc", out_pc, 32'd7);
        tick();
        chk("halt_quiet", 32'(out_valid), 32'd0);
        chk("halt_still", 32'(halted), 32'd1);

        // Reset, restart, fault on out-of-range redirect
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_cleared("rst2");
        start = 1'b1;
        tick();
        start          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd100;
        tick();
        redirect_valid = 1'b0;
        chk("fault_fault", 32'(fault), 32'd1);
        chk("fault_halted", 32'(halted), 32'd1);
        chk("fault_valid", 32'(out_valid), 32'd0);
        chk("fault_addr", imem_addr, 32'd0);
        tick();
        chk("fault_stay_valid", 32'(out_valid), 32'd0);

        // Reset clears fault; nothing appears without a new start
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_cleared("rst3");
        tick();
        tick();
        chk("idle_after_rst", 32'(out_valid), 32'd0);
        chk("idle_after_rst_addr", imem_addr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameters, one per line:
 - MEM_DEPTH, 100, number of instruction words; word-addressed.
 - RESET_PC, 0, PC value after reset.
 - HALT_OPCODE, 6'b111111, opcode in bits [31:26] that stops fetching.
REQ-002 SHALL have ports, one per line:
 - clk  input  1  single clock; all state changes on rising edge.
 - rst_n  input  1  synchronous, active-low reset.
 - start  input  1  begin fetching from IDLE.
 - imem_addr  output  32  word address to the instruction memory.
 - imem_instr  input  32  memory read data, combinational from imem_addr.
 - redirect_valid  input  1  branch/jump redirect request.
 - redirect_pc  input  32  redirect target word address.
 - out_valid  output  1  fetched instruction is available.
 - out_ready  input  1  consumer accepts the instruction.
 - out_instr  output  32  fetched instruction.
 - out_pc  output  32  word address of out_instr.
 - halted  output  1  fetch stopped: halt opcode seen or fault.
 - fault  output  1  redirect target out of range.
REQ-003 SHALL use one clock with synchronous, active-low reset rst_n.

Function
REQ-004 SHALL implement states IDLE, FETCH and HALT.
REQ-005 SHALL drive imem_addr = pc combinationally in every state.
REQ-006 In IDLE, SHALL hold pc and out_valid=0; start=1 -> FETCH next cycle; redirect ignored.
REQ-007 In FETCH, output register free (out_valid=0 or out_ready=1) and no redirect: capture out_instr<=imem_instr, out_pc<=pc, out_valid<=1.
 - Same cycle: pc<=pc+1; pc=MEM_DEPTH-1 wraps to 0.
 - One-instruction-per-cycle throughput; one-cycle latency from pc to out_instr.
REQ-008 In FETCH, out_valid=1 and out_ready=0: SHALL hold pc, out_instr, out_pc and out_valid unchanged.
REQ-009 In FETCH, redirect_valid=1 has highest priority:
 - out_valid<=0 (flush, regardless of out_ready).
 - No capture; pc<=redirect_pc.
REQ-010 redirect_pc >= MEM_DEPTH in FETCH: fault<=1, out_valid<=0, state HALT; pc unchanged.
REQ-011 Captured instruction with bits [31:26]=HALT_OPCODE: delivered normally, pc not incremented, state HALT.
REQ-012 In HALT: halted=1; no further captures; redirect and start ignored.
 - Pending out_valid held until out_ready=1, then 0.
 - Leave HALT only by reset.
REQ-013 Redirect and halt-opcode capture in the same cycle: redirect wins; no capture; state stays FETCH.
REQ-014 Output handshake completes only on out_valid=1 and out_ready=1 at a rising edge.

Reset
REQ-015 rst_n=0 at a rising edge SHALL set pc=RESET_PC, state=IDLE, out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0.
REQ-016 Reset mid-operation SHALL discard any pending un-accepted output; no output appears before the next start.

Structure
REQ-017 MEM_DEPTH, RESET_PC, HALT_OPCODE, state encodings and opcode field positions SHALL live in the shared CPU definitions header used by decode and memory blocks.
REQ-018 PC increment/wrap/load SHALL be one sub-module, fetch_pc_counter (inputs load, load_value, incr; output pc).

Verification
REQ-019 Reset, start=1, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles after start; out_instr equals mem[out_pc]; e.g. mem[0]=32'h80210010.
REQ-020 Backpressure: out_ready=0 for 3 cycles while out_pc=2 -> out_pc=2, out_instr and imem_addr=3 stable; out_ready=1 -> out_pc=3 next cycle.
REQ-021 Redirect: redirect_valid=1, redirect_pc=40 while out_pc=5 valid -> out_valid=0 next cycle; out_pc=40 the cycle after.
REQ-022 Wrap: redirect to 99 -> out_pc 99 then 0.
REQ-023 Halt: mem[7]=32'hFC000000 -> out_pc=7 delivered, halted=1, out_pc=8 never appears; a later redirect is ignored.
REQ-024 Fault and reset: redirect_pc=100 -> fault=1, halted=1, out_valid=0. Then rst_n=0 one cycle -> all outputs cleared and state IDLE.
